alu: RTL and testbench



---
 rtl/alu.sv | 141 ++++++++++++++
 tb/tb_alu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit integer ALU for the JVM-style core: combinational int-arithmetic datapath plus a sticky error flag.
// Optional feature: define ALU_MUL_EN to build the 32x32 signed multiplier for imul (opcode 0011).
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  op_select,
  input  logic        clr_err,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        illegal_op,
  output logic        err_sticky
);

  localparam logic [3:0] OP_IINC  = 4'h0;
  localparam logic [3:0] OP_IADD  = 4'h1;
  localparam logic [3:0] OP_ISUB  = 4'h2;
  localparam logic [3:0] OP_IMUL  = 4'h3;
  localparam logic [3:0] OP_IDIV  = 4'h4;
  localparam logic [3:0] OP_IREM  = 4'h5;
  localparam logic [3:0] OP_IAND  = 4'h6;
  localparam logic [3:0] OP_IOR   = 4'h7;
  localparam logic [3:0] OP_IXOR  = 4'h8;
  localparam logic [3:0] OP_INEG  = 4'h9;
  localparam logic [3:0] OP_ISHL  = 4'hA;
  localparam logic [3:0] OP_ISHR  = 4'hB;
  localparam logic [3:0] OP_IUSHR = 4'hC;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;

  logic [31:0]        sum_inc;
  logic [31:0]        sum_add;
  logic [31:0]        diff_sub;
  logic [31:0]        neg_a;
  logic [4:0]         shamt;
  logic               b_zero;
  logic               div_ovf;
  logic [31:0]        divisor;
  logic signed [31:0] quot;
  logic signed [31:0] rem;
  logic               err_sticky_q;
  logic               err_sticky_d;

  assign sum_inc  = operand_a + 32'd1;
  assign sum_add  = operand_a + operand_b;
  assign diff_sub = operand_a - operand_b;
  assign neg_a    = 32'd0 - operand_a;
  assign shamt    = operand_b[4:0];

  // Divisor is forced to 1 for b==0 and INT_MIN/-1 so the divider never sees an undefined case;
  // INT_MIN/1 happens to be exactly the wrapped quotient required for the overflow case.
  assign b_zero  = (operand_b == 32'd0);
  assign div_ovf = (operand_a == INT_MIN) && (operand_b == 32'hFFFF_FFFF);
  assign divisor = (b_zero || div_ovf) ? 32'd1 : operand_b;
  assign quot    = $signed(operand_a) / $signed(divisor);
  assign rem     = $signed(operand_a) % $signed(divisor);

`ifdef ALU_MUL_EN
  logic [63:0] product;
  logic        mul_ovf;

  assign product = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
  assign mul_ovf = (product[63:32] != {32{product[31]}});
`endif

  always_comb begin
    result_lo   = 32'd0;
    result_hi   = 32'd0;
    div_by_zero = 1'b0;
    overflow    = 1'b0;
    illegal_op  = 1'b0;
    case (op_select)
      OP_IINC: begin
        result_lo = sum_inc;
        overflow  = (operand_a == INT_MAX);
      end
      OP_IADD: begin
        result_lo = sum_add;
        overflow  = (operand_a[31] == operand_b[31]) && (sum_add[31] != operand_a[31]);
      end
      OP_ISUB: begin
        result_lo = diff_sub;
        overflow  = (operand_a[31] != operand_b[31]) && (diff_sub[31] != operand_a[31]);
      end
      OP_IMUL: begin
`ifdef ALU_MUL_EN
        result_lo = product[31:0];
        result_hi = product[63:32];
        overflow  = mul_ovf;
`else
        illegal_op = 1'b1;
`endif
      end
      OP_IDIV: begin
        if (b_zero) begin
          div_by_zero = 1'b1;
        end else begin
          result_lo = quot;
          result_hi = rem;
          overflow  = div_ovf;
        end
      end
      OP_IREM: begin
        if (b_zero) begin
          div_by_zero = 1'b1;
        end else begin
          result_lo = rem;
        end
      end
      OP_IAND:  result_lo = operand_a & operand_b;
      OP_IOR:   result_lo = operand_a | operand_b;
      OP_IXOR:  result_lo = operand_a ^ operand_b;
      OP_INEG: begin
        result_lo = neg_a;
        overflow  = (operand_a == INT_MIN);
      end
      OP_ISHL:  result_lo = operand_a << shamt;
      OP_ISHR:  result_lo = $signed(operand_a) >>> shamt;
      OP_IUSHR: result_lo = operand_a >> shamt;
      default:  illegal_op = 1'b1;
    endcase
  end

  // Clear has priority so the core can acknowledge and discard an error raised in the same cycle.
  assign err_sticky_d = clr_err ? 1'b0 : (err_sticky_q | div_by_zero | illegal_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table-driven vectors through a scoreboard queue, random add/sub/xor
// against an integer model, and sticky-error sequencing including async reset.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  op_select;
  logic        clr_err;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;
  logic        overflow;
  logic        illegal_op;
  logic        err_sticky;

  // Packed expectation: {result_lo, result_hi, div_by_zero, overflow, illegal_op}
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [66:0] exp;
  } vec_t;

  logic [66:0] sbQ[$];
  logic [66:0] observed;
  int          vecCount;
  int          missCount;

  assign observed = {result_lo, result_hi, div_by_zero, overflow, illegal_op};

  alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_select   (op_select),
    .clr_err     (clr_err),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .illegal_op  (illegal_op),
    .err_sticky  (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; results are sampled 2 time units later, well before the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    op_select = v.op;
    operand_a = v.a;
    operand_b = v.b;
    sbQ.push_back(v.exp);
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    clr_err   = 1'b0;
    op_select = 4'h4;
    operand_a = 32'd1;
    operand_b = 32'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_sticky: got %b expected 0", err_sticky);
    end
    @(negedge clk);
    op_select = 4'h1;
    operand_b = 32'd1;
    rst_n     = 1'b1;
  endtask

  task automatic test_arith();
    vec_t        v[11];
    logic [66:0] exp;
    v = '{
      '{4'h0, 32'h0000_00FF, 32'h0,          {32'h0000_0100, 32'h0, 3'b000}},
      '{4'h0, 32'h7FFF_FFFF, 32'h0,          {32'h8000_0000, 32'h0, 3'b010}},
      '{4'h1, 32'h0000_00FF, 32'h0000_00FF,  {32'h0000_01FE, 32'h0, 3'b000}},
      '{4'h1, 32'h7FFF_FFFF, 32'h0000_0001,  {32'h8000_0000, 32'h0, 3'b010}},
      '{4'h1, 32'h8000_0000, 32'h8000_0000,  {32'h0000_0000, 32'h0, 3'b010}},
      '{4'h2, 32'h0000_0005, 32'h0000_0007,  {32'hFFFF_FFFE, 32'h0, 3'b000}},
      '{4'h2, 32'h8000_0000, 32'h0000_0001,  {32'h7FFF_FFFF, 32'h0, 3'b010}},
      '{4'h9, 32'h8000_0000, 32'h0,          {32'h8000_0000, 32'h0, 3'b010}},
      '{4'h9, 32'h0000_0005, 32'h0,          {32'hFFFF_FFFB, 32'h0, 3'b000}},
      '{4'h6, 32'h0000_00FF, 32'h0000_00FF,  {32'h0000_00FF, 32'h0, 3'b000}},
      '{4'h7, 32'h0000_00F0, 32'h0000_000F,  {32'h0000_00FF, 32'h0, 3'b000}}
    };
    for (int i = 0; i < 11; i++) begin
      applyStimulus(v[i]);
      #2;
      exp = sbQ.pop_front();
      vecCount++;
      if (observed !== exp) begin
        missCount++;
        $display("[TB] FAIL arith[%0d] op=%h: got %h expected %h", i, v[i].op, observed, exp);
      end
    end
  endtask

  task automatic test_divide();
    vec_t        v[9];
    logic [66:0] exp;
    v = '{
      '{4'h4, 32'h0000_00FF, 32'h0000_00FF,  {32'h0000_0001, 32'h0000_0000, 3'b000}},
      '{4'h4, 32'hFFFF_FFF9, 32'h0000_0002,  {32'hFFFF_FFFD, 32'hFFFF_FFFF, 3'b000}},
      '{4'h4, 32'h0000_0007, 32'hFFFF_FFFE,  {32'hFFFF_FFFD, 32'h0000_0001, 3'b000}},
      '{4'h4, 32'h0000_1234, 32'h0000_0000,  {32'h0000_0000, 32'h0000_0000, 3'b100}},
      '{4'h4, 32'h8000_0000, 32'hFFFF_FFFF,  {32'h8000_0000, 32'h0000_0000, 3'b010}},
      '{4'h5, 32'hFFFF_FFF9, 32'h0000_0002,  {32'hFFFF_FFFF, 32'h0000_0000, 3'b000}},
      '{4'h5, 32'h0000_0007, 32'hFFFF_FFFE,  {32'h0000_0001, 32'h0000_0000, 3'b000}},
      '{4'h5, 32'h0000_0009, 32'h0000_0000,  {32'h0000_0000, 32'h0000_0000, 3'b100}},
      '{4'h5, 32'h8000_0000, 32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0000, 3'b000}}
    };
    for (int i = 0; i < 9; i++) begin
      applyStimulus(v[i]);
      #2;
      exp = sbQ.pop_front();
      vecCount++;
      if (observed !== exp) begin
        missCount++;
        $display("[TB] FAIL divide[%0d] op=%h: got %h expected %h", i, v[i].op, observed, exp);
      end
    end
  endtask

  task automatic test_shift_logic();
    vec_t        v[6];
    logic [66:0] exp;
    v = '{
      '{4'hB, 32'h8000_0000, 32'h0000_0021,  {32'hC000_0000, 32'h0, 3'b000}},
      '{4'hC, 32'h8000_0000, 32'h0000_0021,  {32'h4000_0000, 32'h0, 3'b000}},
      '{4'hA, 32'h0000_0001, 32'h0000_001F,  {32'h8000_0000, 32'h0, 3'b000}},
      '{4'hA, 32'h0000_0001, 32'hFFFF_FFE0,  {32'h0000_0001, 32'h0, 3'b000}},
      '{4'hB, 32'h7000_0000, 32'h0000_0004,  {32'h0700_0000, 32'h0, 3'b000}},
      '{4'h8, 32'h0000_00F0, 32'h0000_00FF,  {32'h0000_000F, 32'h0, 3'b000}}
    };
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[i]);
      #2;
      exp = sbQ.pop_front();
      vecCount++;
      if (observed !== exp) begin
        missCount++;
        $display("[TB] FAIL shift_logic[%0d] op=%h: got %h expected %h", i, v[i].op, observed, exp);
      end
    end
  endtask

  task automatic test_mul_reserved();
    vec_t        v[6];
    logic [66:0] exp;
`ifdef ALU_MUL_EN
    v[0] = '{4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0000_0001, 32'h0000_0000, 3'b000}};
    v[1] = '{4'h3, 32'h0001_0000, 32'h0001_0000, {32'h0000_0000, 32'h0000_0001, 3'b010}};
    v[2] = '{4'h3, 32'hFFFF_FFFF, 32'h0000_0001, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000}};
`else
    v[0] = '{4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h0, 3'b001}};
    v[1] = '{4'h3, 32'h0001_0000, 32'h0001_0000, {32'h0, 32'h0, 3'b001}};
    v[2] = '{4'h3, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0, 32'h0, 3'b001}};
`endif
    v[3] = '{4'hD, 32'h0000_00FF, 32'h0000_00FF, {32'h0, 32'h0, 3'b001}};
    v[4] = '{4'hE, 32'h0000_00FF, 32'h0000_00FF, {32'h0, 32'h0, 3'b001}};
    v[5] = '{4'hF, 32'h0000_00FF, 32'h0000_00FF, {32'h0, 32'h0, 3'b001}};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[i]);
      #2;
      exp = sbQ.pop_front();
      vecCount++;
      if (observed !== exp) begin
        missCount++;
        $display("[TB] FAIL mul_reserved[%0d] op=%h: got %h expected %h", i, v[i].op, observed, exp);
      end
    end
  endtask

  // Integer model with 64-bit arithmetic: overflow means the true result is outside the int range.
  task automatic test_random_addsub();
    vec_t        v;
    logic [66:0] exp;
    longint      sa;
    longint      sb;
    longint      r;
    logic        ovf;
    for (int i = 0; i < 24; i++) begin
      v.a  = $urandom();
      v.b  = (i % 4 == 0) ? (v.a ^ 32'h8000_0000) : $urandom();
      v.op = 4'(1 + (i % 3));
      if (v.op == 4'h3) v.op = 4'h8;
      sa = longint'($signed(v.a));
      sb = longint'($signed(v.b));
      if (v.op == 4'h1) r = sa + sb;
      else if (v.op == 4'h2) r = sa - sb;
      else r = longint'($signed(v.a ^ v.b));
      ovf   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      v.exp = {r[31:0], 32'h0, 1'b0, ovf, 1'b0};
      applyStimulus(v);
      #2;
      exp = sbQ.pop_front();
      vecCount++;
      if (observed !== exp) begin
        missCount++;
        $display("[TB] FAIL random[%0d] op=%h a=%h b=%h: got %h expected %h",
                 i, v.op, v.a, v.b, observed, exp);
      end
    end
  endtask

  task automatic test_sticky();
    @(negedge clk);
    op_select = 4'h1;
    clr_err   = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #2;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL sticky_clear_start: got %b expected 0", err_sticky);
    end
    // Divide by zero: no effect before the clock edge, then latched and held.
    op_select = 4'h4;
    operand_a = 32'd5;
    operand_b = 32'd0;
    #1;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL sticky_before_edge: got %b expected 0", err_sticky);
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL sticky_set_dbz: got %b expected 1", err_sticky);
    end
    @(negedge clk);
    op_select = 4'h1;
    operand_b = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL sticky_hold: got %b expected 1", err_sticky);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL sticky_clr_pulse: got %b expected 0", err_sticky);
    end
    // Clear and a reserved opcode in the same cycle: clear wins, then the error latches.
    @(negedge clk);
    op_select = 4'hF;
    @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL sticky_clr_priority: got %b expected 0", err_sticky);
    end
    @(negedge clk);
    clr_err = 1'b0;
    @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL sticky_set_illegal: got %b expected 1", err_sticky);
    end
    // Async reset in mid-cycle clears without a clock edge.
    @(negedge clk);
    op_select = 4'h1;
    #2 rst_n = 1'b0;
    #1;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL sticky_async_reset: got %b expected 0", err_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vecCount++;
    if (err_sticky !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL sticky_after_reset: got %b expected 0", err_sticky);
    end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    test_reset();
    test_arith();
    test_divide();
    test_shift_logic();
    test_mul_reserved();
    test_random_addsub();
    test_sticky();
    if (sbQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
